detect_switch_edge_multi: RTL and testbench

DETECT_SWITCH_EDGE_MULTI -- requirements
Module: detect_switch_edge_multi

---
 rtl/detect_switch_edge_multi.sv | 88 ++++++++
 tb/tb_detect_switch_edge_multi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/detect_switch_edge_multi.sv
// Multi-channel switch debouncer: 2-flop synchronizer, per-channel stability counter,
// debounced level plus registered press/release pulses and a registered any-event flag.
module detect_switch_edge_multi #(
  parameter int NUM_CH          = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sw,
  output logic [NUM_CH-1:0] pressed,
  output logic [NUM_CH-1:0] pos_edge_pulse,
  output logic [NUM_CH-1:0] neg_edge_pulse,
  output logic [NUM_CH-1:0] either_edge_pulse,
  output logic              any_event
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_CH-1:0] IDLE_PIN = {NUM_CH{ACTIVE_LOW != 0}};

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] w_act;
  logic [NUM_CH-1:0] w_either;
  logic              r_any;

  // Reset loads the released pin level so a held switch looks like a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_PIN;
      r_sync2 <= IDLE_PIN;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pos;
    logic             r_neg;

    // Counter only runs while the synchronized level disagrees; any agreement abandons the change.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pos   <= 1'b0;
        r_neg   <= 1'b0;
      end else begin
        r_pos <= 1'b0;
        r_neg <= 1'b0;
        if (w_act[g] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt >= CNT_LAST) begin
          r_level <= w_act[g];
          r_cnt   <= '0;
          r_pos   <= w_act[g];
          r_neg   <= ~w_act[g];
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign pressed[g]        = r_level;
    assign pos_edge_pulse[g] = r_pos;
    assign neg_edge_pulse[g] = r_neg;
  end

  assign w_either          = pos_edge_pulse | neg_edge_pulse;
  assign either_edge_pulse = w_either;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_either;
    end
  end

  assign any_event = r_any;

endmodule

// File: tb/tb_detect_switch_edge_multi.sv
// Scoreboard bench: stimulus pushes expected pulse events, negedge monitors pop and compare.
// DUT A: 4 channels, D=4, active-low. DUT B: 1 channel, D=1, active-high.
`timescale 1ns/1ps
module tb_detect_switch_edge_multi;

  typedef struct {
    int         cyc;
    logic [3:0] pos;
    logic [3:0] neg;
    logic [3:0] lvl;
  } ev_t;

  logic       clk;
  logic       rstA_n;
  logic       rstB_n;
  logic [3:0] swA;
  logic [3:0] pressedA, posA, negA, eitherA;
  logic       anyA;
  logic [0:0] swB;
  logic [0:0] pressedB, posB, negB, eitherB;
  logic       anyB;

  int  edgeN = 0;
  int  assertCount = 0;
  int  failCount = 0;
  ev_t evQA[$];
  ev_t evQB[$];
  int  anyQA[$];
  int  anyQB[$];
  ev_t monEA, monEB;
  int  monCA, monCB;

  detect_switch_edge_multi #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) u_dutA (
    .clk(clk), .rst_n(rstA_n), .sw(swA), .pressed(pressedA),
    .pos_edge_pulse(posA), .neg_edge_pulse(negA),
    .either_edge_pulse(eitherA), .any_event(anyA)
  );

  detect_switch_edge_multi #(.NUM_CH(1), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0)) u_dutB (
    .clk(clk), .rst_n(rstB_n), .sw(swB), .pressed(pressedB),
    .pos_edge_pulse(posB), .neg_edge_pulse(negB),
    .either_edge_pulse(eitherB), .any_event(anyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeN++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeN);
    end
  endtask

  // A change applied now is first sampled next edge; pulse lands D+2 edges later.
  task automatic applyStimulus(input logic [3:0] val, input logic [3:0] pos, input logic [3:0] neg,
                               input logic [3:0] lvl, input int hold);
    swA = val;
    if ((pos | neg) != 4'd0) begin
      evQA.push_back('{edgeN + 6, pos, neg, lvl});
      anyQA.push_back(edgeN + 7);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic applyStimulusB(input logic val, input logic pos, input logic neg, input int hold);
    swB = val;
    evQB.push_back('{edgeN + 3, {3'd0, pos}, {3'd0, neg}, {3'd0, pos}});
    anyQB.push_back(edgeN + 4);
    repeat (hold) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (posA != 4'd0 || negA != 4'd0 || (evQA.size() > 0 && evQA[0].cyc <= edgeN)) begin
      if (evQA.size() == 0) begin
        checkOutput("A unexpected pulse", {posA, negA}, 32'd0);
      end else begin
        monEA = evQA.pop_front();
        checkOutput("A pulse edge", edgeN, monEA.cyc);
        checkOutput("A pos", posA, monEA.pos);
        checkOutput("A neg", negA, monEA.neg);
        checkOutput("A pressed", pressedA, monEA.lvl);
        checkOutput("A either", eitherA, monEA.pos | monEA.neg);
      end
    end
    if (anyA || (anyQA.size() > 0 && anyQA[0] <= edgeN)) begin
      if (anyQA.size() == 0) begin
        checkOutput("A unexpected any_event", anyA, 32'd0);
      end else begin
        monCA = anyQA.pop_front();
        checkOutput("A any_event edge", edgeN, monCA);
        checkOutput("A any_event", anyA, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (posB != 1'b0 || negB != 1'b0 || (evQB.size() > 0 && evQB[0].cyc <= edgeN)) begin
      if (evQB.size() == 0) begin
        checkOutput("B unexpected pulse", {posB, negB}, 32'd0);
      end else begin
        monEB = evQB.pop_front();
        checkOutput("B pulse edge", edgeN, monEB.cyc);
        checkOutput("B pos", posB, monEB.pos);
        checkOutput("B neg", negB, monEB.neg);
        checkOutput("B pressed", pressedB, monEB.lvl);
        checkOutput("B either", eitherB, monEB.pos | monEB.neg);
      end
    end
    if (anyB || (anyQB.size() > 0 && anyQB[0] <= edgeN)) begin
      if (anyQB.size() == 0) begin
        checkOutput("B unexpected any_event", anyB, 32'd0);
      end else begin
        monCB = anyQB.pop_front();
        checkOutput("B any_event edge", edgeN, monCB);
        checkOutput("B any_event", anyB, 32'd1);
      end
    end
  end

  initial begin
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    swA    = 4'hF;
    swB    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset pressedA", pressedA, 32'd0);
    checkOutput("reset posA", posA, 32'd0);
    checkOutput("reset negA", negA, 32'd0);
    checkOutput("reset anyA", anyA, 32'd0);
    checkOutput("reset pressedB", pressedB, 32'd0);
    checkOutput("reset posB", posB, 32'd0);
    checkOutput("reset anyB", anyB, 32'd0);
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single press and release on channel 0.
    applyStimulus(4'hE, 4'b0001, 4'b0000, 4'b0001, 10);
    applyStimulus(4'hF, 4'b0000, 4'b0001, 4'b0000, 10);

    // Three-cycle bounce must be invisible.
    applyStimulus(4'hE, 4'b0000, 4'b0000, 4'b0000, 3);
    applyStimulus(4'hF, 4'b0000, 4'b0000, 4'b0000, 12);
    checkOutput("bounce pressed", pressedA, 32'd0);
    checkOutput("bounce counter", u_dutA.g_ch[0].r_cnt, 32'd0);

    // Simultaneous press, then mixed press/release in one cycle.
    applyStimulus(4'h6, 4'b1001, 4'b0000, 4'b1001, 10);
    applyStimulus(4'hC, 4'b0010, 4'b1000, 4'b0011, 10);
    applyStimulus(4'hF, 4'b0000, 4'b0011, 4'b0000, 10);

    // Reset mid-debounce, switch held pressed through release.
    applyStimulus(4'hE, 4'b0000, 4'b0000, 4'b0000, 4);
    checkOutput("pre-reset counter", u_dutA.g_ch[0].r_cnt, 32'd2);
    rstA_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid reset pressedA", pressedA, 32'd0);
    checkOutput("mid reset counter", u_dutA.g_ch[0].r_cnt, 32'd0);
    rstA_n = 1'b1;
    evQA.push_back('{edgeN + 6, 4'b0001, 4'b0000, 4'b0001});
    anyQA.push_back(edgeN + 7);
    repeat (10) @(negedge clk);
    applyStimulus(4'hF, 4'b0000, 4'b0001, 4'b0000, 10);

    // D=1 active-high: press, release, and a one-cycle glitch that is accepted both ways.
    applyStimulusB(1'b1, 1'b1, 1'b0, 6);
    applyStimulusB(1'b0, 1'b0, 1'b1, 6);
    applyStimulusB(1'b1, 1'b1, 1'b0, 1);
    applyStimulusB(1'b0, 1'b0, 1'b1, 8);

    for (int i = 0; i < 50 && (evQA.size() + evQB.size() + anyQA.size() + anyQB.size()) != 0; i++)
      @(negedge clk);
    checkOutput("A events drained", evQA.size(), 32'd0);
    checkOutput("B events drained", evQB.size(), 32'd0);
    checkOutput("A any drained", anyQA.size(), 32'd0);
    checkOutput("B any drained", anyQB.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
